// File: rtl/bus_pkg.sv
// Shared bus types: transaction encoding, slave FSM states and the error
// counter width used by bus_mem_slave and its monitors.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2,
    BUS_ERROR = 2'd3
  } bus_transaction_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } slave_state_t;

  localparam int ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/bus_mem_array.sv
// Synchronous single-port RAM with a registered read port (1-cycle latency).
// The output register reads back zero on any cycle without a read strobe.
module bus_mem_array #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_idx];
    else           r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory target on bus_if: req/ack handshake with a fixed
// number of wait states, range checking, abort detection and error counting.
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     we,
  input  logic                     req,
  input  logic                     valid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     ack,
  output bus_transaction_t         txn,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = DEPTH;

  slave_state_t            r_state, w_next_state;
  logic [3:0]              r_cnt, w_cnt_next;
  bus_transaction_t        r_txn, w_txn_next;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic                    r_ack;
  logic                    w_err_inc;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_we;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_addr_sel;
  logic                    w_we_sel;
  logic                    w_oor;
  logic                    w_mem_re, w_mem_we;
  logic [DATA_WIDTH-1:0]   w_rdata;

  // With zero wait states the RAM is addressed straight from the bus in the
  // accept cycle so the registered read data still coincides with ack.
  assign w_accept   = (r_state == S_IDLE) && req && valid;
  assign w_addr_sel = w_accept ? addr : r_addr;
  assign w_we_sel   = w_accept ? we : r_we;
  assign w_oor      = {1'b0, w_addr_sel} >= DEPTH_EXT;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_txn_next   = r_txn;
    w_err_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txn_next = BUS_IDLE;
        if (w_accept) begin
          w_cnt_next = 4'(WAIT_STATES);
          w_txn_next = we ? BUS_WRITE : BUS_READ;
          if (WAIT_STATES == 0) begin
            w_next_state = S_RESP;
            if (w_oor) begin
              w_txn_next = BUS_ERROR;
              w_err_inc  = 1'b1;
            end
          end else begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          w_next_state = S_IDLE;
          w_cnt_next   = '0;
          w_txn_next   = BUS_ERROR;
          w_err_inc    = 1'b1;
        end else if (r_cnt <= 4'd1) begin
          w_next_state = S_RESP;
          w_cnt_next   = '0;
          if (w_oor) begin
            w_txn_next = BUS_ERROR;
            w_err_inc  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: w_next_state = S_HOLD;
      S_HOLD: begin
        if (!req) begin
          w_next_state = S_IDLE;
          w_txn_next   = BUS_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_txn     <= BUS_IDLE;
      r_ack     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_txn   <= w_txn_next;
      r_ack   <= (w_next_state == S_RESP);
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_we    <= we;
    end
  end

  // Read strobe fires the cycle before S_RESP; write commits at the end of S_RESP.
  assign w_mem_re = (w_next_state == S_RESP) && !w_we_sel && !w_oor;
  assign w_mem_we = (r_state == S_RESP) && r_we && !w_oor;

  bus_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_re    (w_mem_re),
    .i_we    (w_mem_we),
    .i_idx   (w_addr_sel[IDX_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign rdata   = w_rdata;
  assign ack     = r_ack;
  assign txn     = r_txn;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: three instances with 2, 0 and 4 wait
// states; expected ack responses are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_bus_mem_slave;
  import bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] addr [ND];
  logic [DW-1:0] wdata [ND];
  logic we [ND];
  logic req [ND];
  logic valid [ND];
  logic [DW-1:0] rdata [ND];
  logic ack [ND];
  bus_transaction_t txn [ND];
  logic [15:0] err_cnt [ND];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int d;
    logic [31:0] rdata;
    bus_transaction_t txn;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : gen_dut
      bus_mem_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (g == 0 ? 2 : (g == 1 ? 0 : 4))
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr[g]),
        .wdata   (wdata[g]),
        .we      (we[g]),
        .req     (req[g]),
        .valid   (valid[g]),
        .rdata   (rdata[g]),
        .ack     (ack[g]),
        .txn     (txn[g]),
        .err_cnt (err_cnt[g])
      );
    end
  endgenerate

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (rst_n && ack[d]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: dut%0d acked at cycle %0d with none expected", d, cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_dut", 32'(d), 32'(e.d));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("ack_rdata", rdata[d], e.rdata);
          chk("ack_txn", 32'(txn[d]), 32'(e.txn));
        end
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, output int e_cyc);
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; we[d] = w; req[d] = 1'b1; valid[d] = 1'b1;
    @(posedge clk);
    #1;
    e_cyc = cyc;
  endtask

  task automatic do_txn(input int d, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bus_transaction_t exp_txn, input int hold,
                        output int e_cyc);
    bit seen;
    issue(d, a, w, wd, e_cyc);
    sb.push_back('{d, exp_rd, exp_txn, e_cyc + ws_of(d)});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack[d]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: dut%0d addr %h no ack within 40 cycles", d, a);
    end
    repeat (hold) @(negedge clk);
    @(negedge clk);
    req[d] = 1'b0; valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int e1, e2;
    for (int d = 0; d < ND; d++) begin
      addr[d] = '0; wdata[d] = '0; we[d] = 1'b0; req[d] = 1'b0; valid[d] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_ack", 32'(ack[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_txn", 32'(txn[d]), 32'(BUS_IDLE));
      chk("rst_err_cnt", 32'(err_cnt[d]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back with two wait states.
    do_txn(0, 32'd5, 1'b1, 32'hDEAD_BEEF, 32'd0, BUS_WRITE, 0, e1);
    do_txn(0, 32'd5, 1'b0, 32'd0, 32'hDEAD_BEEF, BUS_READ, 0, e1);
    chk("err_after_rw", 32'(err_cnt[0]), 32'd0);

    // req without valid is ignored.
    @(negedge clk);
    addr[0] = 32'd5; we[0] = 1'b0; req[0] = 1'b1; valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_valid_txn", 32'(txn[0]), 32'(BUS_IDLE));
    req[0] = 1'b0;

    // Out-of-range read and write; word 3 aliases addr DEPTH+3 in the low bits.
    do_txn(0, 32'd3, 1'b1, 32'h1234_5678, 32'd0, BUS_WRITE, 0, e1);
    do_txn(0, 32'(DEPTH), 1'b0, 32'd0, 32'd0, BUS_ERROR, 0, e1);
    do_txn(0, 32'(DEPTH + 3), 1'b1, 32'hFFFF_FFFF, 32'd0, BUS_ERROR, 0, e1);
    chk("err_after_oor", 32'(err_cnt[0]), 32'd2);
    do_txn(0, 32'd3, 1'b0, 32'd0, 32'h1234_5678, BUS_READ, 0, e1);

    // req held high after ack: single ack only, then normal re-accept.
    do_txn(0, 32'd5, 1'b0, 32'd0, 32'hDEAD_BEEF, BUS_READ, 5, e1);
    do_txn(0, 32'd5, 1'b0, 32'd0, 32'hDEAD_BEEF, BUS_READ, 0, e1);

    // Reset pulse during the wait phase of a write.
    do_txn(0, 32'd9, 1'b1, 32'hAAAA_0009, 32'd0, BUS_WRITE, 0, e1);
    issue(0, 32'd9, 1'b1, 32'h5555_5555, e1);
    @(negedge clk);
    rst_n = 1'b0;
    req[0] = 1'b0; valid[0] = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack[0]), 32'd0);
    chk("midrst_rdata", rdata[0], 32'd0);
    chk("midrst_txn", 32'(txn[0]), 32'(BUS_IDLE));
    chk("midrst_err_cnt", 32'(err_cnt[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_txn(0, 32'd9, 1'b0, 32'd0, 32'hAAAA_0009, BUS_READ, 0, e1);

    // Zero wait states: back-to-back reads, accepts three cycles apart.
    do_txn(1, 32'd20, 1'b1, 32'hCAFE_0020, 32'd0, BUS_WRITE, 0, e1);
    do_txn(1, 32'd21, 1'b1, 32'hCAFE_0021, 32'd0, BUS_WRITE, 0, e1);
    do_txn(1, 32'd20, 1'b0, 32'd0, 32'hCAFE_0020, BUS_READ, 0, e1);
    do_txn(1, 32'd21, 1'b0, 32'd0, 32'hCAFE_0021, BUS_READ, 0, e2);
    chk("accept_spacing", 32'(e2 - e1), 32'd3);

    // Error counter saturation.
    @(negedge clk);
    force gen_dut[1].u_dut.r_err_cnt = 16'hFFFE;
    @(negedge clk);
    release gen_dut[1].u_dut.r_err_cnt;
    chk("forced_err_cnt", 32'(err_cnt[1]), 32'h0000_FFFE);
    do_txn(1, 32'd2000, 1'b0, 32'd0, 32'd0, BUS_ERROR, 0, e1);
    do_txn(1, 32'd5000, 1'b1, 32'h0BAD_F00D, 32'd0, BUS_ERROR, 0, e1);
    chk("sat_err_cnt", 32'(err_cnt[1]), 32'h0000_FFFF);
    do_txn(1, 32'd4096, 1'b0, 32'd0, 32'd0, BUS_ERROR, 0, e1);
    chk("sat_hold_err_cnt", 32'(err_cnt[1]), 32'h0000_FFFF);

    // Abort with four wait states: req drops in the first wait cycle.
    do_txn(2, 32'd7, 1'b1, 32'h7777_0007, 32'd0, BUS_WRITE, 0, e1);
    issue(2, 32'd7, 1'b1, 32'hBAD0_BAD0, e1);
    @(negedge clk);
    req[2] = 1'b0; valid[2] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_txn", 32'(txn[2]), 32'(BUS_ERROR));
    chk("abort_err_cnt", 32'(err_cnt[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_txn_after", 32'(txn[2]), 32'(BUS_IDLE));
    chk("abort_err_cnt_after", 32'(err_cnt[2]), 32'd1);
    repeat (6) @(negedge clk);
    do_txn(2, 32'd7, 1'b0, 32'd0, 32'h7777_0007, BUS_READ, 0, e1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
